aho_table_writer: RTL and testbench
===================================

Name: aho_table_writer

Overview:
- Loader that fills the Aho-Corasick goto and failure tables, which the table reader block scans during matching.
- Accepts a byte stream over a valid/ready handshake, parses a goto section and a failure section, and issues one registered write per cycle to the four table RAMs: current_state, chara, next_state, failure.
- Unused goto entries are written with an invalid current_state, so a partial load never leaves stale matches.
- Sits between the host/config path and the table memories. Runs before matching starts.

Parameters:
DEPTH, 32, entries per table (max goto entries and max failure entries)
ADDR_W, 5, table address width, log2(DEPTH)
STATE_W, 8, state and data byte width
CHARA_W, 4, character code width stored in the chara table
INVALID_STATE, 8'hFF, current_state fill value for unused goto entries

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  reset, synchronous, active-low
START  input  1  one-cycle request to begin a load; honoured only in IDLE
IN_VALID  input  1  IN_DATA holds a valid byte
IN_READY  output  1  writer accepts a byte this cycle
IN_DATA  input  8  stream byte
WR_EN  output  1  table write strobe
WR_SEL  output  2  target table: 0 current_state, 1 chara, 2 next_state, 3 failure
WR_ADDR  output  ADDR_W  table entry index
WR_DATA  output  8  write data; chara writes carry the code in [3:0] with [7:4] = 0
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse when a load completes successfully
ERR  output  1  sticky error flag, cleared by the next accepted START or by reset
GOTO_COUNT  output  6  number of goto entries loaded (N); valid once DONE has pulsed

Behaviour:
- Reset (RST=0 at a clock edge), outputs: IN_READY=0, WR_EN=0, WR_SEL=0, WR_ADDR=0, WR_DATA=0, BUSY=0, DONE=0, ERR=0, GOTO_COUNT=0.
- Reset, internal state: FSM goes to IDLE.
- Reset mid-load: abort immediately. No further writes. Table contents are not cleared.
- Handshake: a byte transfers on a rising edge where IN_VALID=1 and IN_READY=1.
- IN_READY is a registered function of the FSM state: high in GCNT, GOTO, FCNT and FAIL; low in every other state.
- Write latency: each write is registered. WR_EN/WR_SEL/WR_ADDR/WR_DATA are asserted exactly one cycle after the accepting edge, or one cycle after each fill step. Never more than one write per cycle.
- Stream format:
  - Byte N = goto count.
  - N triples of (current_state, chara, next_state).
  - Byte M = failure count.
  - M failure bytes; byte k is written to failure[k].
- FSM states: IDLE, GCNT, GOTO, GFILL, FCNT, FAIL, FFILL, FIN, ERROR.
- IDLE:
  - START=1 clears ERR and GOTO_COUNT, then goes to GCNT.
  - START in any other state is ignored.
- GCNT: accept N.
  - N in 1..DEPTH: latch N, set GOTO_COUNT=N, go to GOTO with entry=0 and field=0.
  - N=0 or N>DEPTH: set ERR and go to ERROR. No write.
- GOTO: field sequence 0, 1, 2. Writes WR_SEL=field, WR_ADDR=entry.
  - Field 1 byte with [7:4] != 0: set ERR, go to ERROR, suppress that write.
  - After field 2, entry increments.
  - After the write for entry N-1 field 2: go to GFILL if N<DEPTH, else go to FCNT.
- GFILL: IN_READY=0. One write per cycle with WR_SEL=0, data INVALID_STATE, addresses N..DEPTH-1 ascending (DEPTH-N cycles). Then go to FCNT.
- FCNT: accept M.
  - M in 1..DEPTH: go to FAIL.
  - M=0 or M>DEPTH: set ERR, go to ERROR.
- FAIL: writes WR_SEL=3, addresses 0..M-1. After the last write, go to FFILL if M<DEPTH, else go to FIN.
- FFILL: IN_READY=0. Writes WR_SEL=3, data 0, addresses M..DEPTH-1 ascending.
- FIN: DONE=1 for one cycle, then go to IDLE (BUSY falls with it).
- ERROR: IN_READY=0, no writes, BUSY=1. The next cycle goes to IDLE; ERR stays 1.
- IN_VALID gaps: any number of idle cycles between bytes is legal. The FSM holds, IN_READY stays high, and no writes occur.
- Width rule: entry and address counters are ADDR_W+1 bits wide internally, so a count of DEPTH is representable. WR_ADDR outputs only the low ADDR_W bits.

Test Plan:
- Minimal load: stream 01, 00, 0C, 01, 01, 00. Required writes: (0,0,00), (1,0,0C), (2,0,01), then sel0 addrs 1..31 = FF, then (3,0,00), then sel3 addrs 1..31 = 00. DONE pulses once; GOTO_COUNT=1; ERR=0.
- Full tables: N=32 with 96 goto bytes, then M=32 failure bytes. No GFILL or FFILL cycles occur. The last write is (3,31,x), DONE pulses on the next cycle, and the total write count is 128.
- Bad chara: N=2, first triple chara byte = 1C. ERR=1, that chara write is suppressed, IN_READY drops, the FSM returns to IDLE. A following START clears ERR.
- Count errors: N=0 -> ERR with no writes; N=33 -> ERR; valid goto section followed by M=0 -> ERR with no failure writes.
- Backpressure and gaps: random IN_VALID gaps of 0-5 cycles during N=3, M=4. The write sequence is identical to the gap-free run, and IN_READY=0 throughout GFILL and FFILL.
- Reset mid-operation and ignored START: assert RST=0 during GFILL -> next cycle all outputs are at reset values, and no write follows reset release until START. START pulsed while BUSY=1 causes no restart.

Source files
------------

// File: rtl/aho_table_writer_if.sv
// aho_table_writer_if
// Groups the host-side control and byte stream together with the table write
// bus of the Aho-Corasick table loader.
//   master : host / config side (drives START, IN_VALID, IN_DATA)
//   slave  : the table writer (drives IN_READY, WR_*, BUSY, DONE, ERR, GOTO_COUNT)
// Signals:
//   START       one-cycle load request
//   IN_VALID    IN_DATA holds a valid byte
//   IN_READY    writer accepts a byte this cycle
//   IN_DATA     stream byte
//   WR_EN       table write strobe
//   WR_SEL      target table: 0 current_state, 1 chara, 2 next_state, 3 failure
//   WR_ADDR     table entry index
//   WR_DATA     table write data
//   BUSY        writer is not idle
//   DONE        one-cycle pulse on successful completion
//   ERR         sticky error flag
//   GOTO_COUNT  number of goto entries of the current load
interface aho_table_writer_if #(
  parameter int ADDR_W  = 5,
  parameter int STATE_W = 8
);
  logic               START;
  logic               IN_VALID;
  logic               IN_READY;
  logic [STATE_W-1:0] IN_DATA;
  logic               WR_EN;
  logic [1:0]         WR_SEL;
  logic [ADDR_W-1:0]  WR_ADDR;
  logic [STATE_W-1:0] WR_DATA;
  logic               BUSY;
  logic               DONE;
  logic               ERR;
  logic [ADDR_W:0]    GOTO_COUNT;

  modport master (
    output START, IN_VALID, IN_DATA,
    input  IN_READY, WR_EN, WR_SEL, WR_ADDR, WR_DATA, BUSY, DONE, ERR, GOTO_COUNT
  );

  modport slave (
    input  START, IN_VALID, IN_DATA,
    output IN_READY, WR_EN, WR_SEL, WR_ADDR, WR_DATA, BUSY, DONE, ERR, GOTO_COUNT
  );
endinterface

// File: rtl/aho_table_writer.sv
// aho_table_writer
// Parses a byte stream (goto count, goto triples, failure count, failure bytes)
// and fills the four Aho-Corasick table RAMs with one registered write per
// cycle. Goto entries beyond the loaded count are filled with INVALID_STATE in
// the current_state table, and unused failure entries are filled with 0, so a
// short load never leaves stale entries behind.
// Ports:
//   CLK  rising-edge system clock
//   RST  synchronous active-low reset
//   bus  aho_table_writer_if slave modport (stream in, table writes out, status)
module aho_table_writer #(
  parameter int                 DEPTH         = 32,
  parameter int                 ADDR_W        = 5,
  parameter int                 STATE_W       = 8,
  parameter int                 CHARA_W       = 4,
  parameter logic [STATE_W-1:0] INVALID_STATE = 8'hFF
) (
  input logic               CLK,
  input logic               RST,
  aho_table_writer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    GCNT,
    GOTO,
    GFILL,
    FCNT,
    FAIL,
    FFILL,
    FIN,
    ERROR
  } state_e;

  // Counters are one bit wider than the address so a count of DEPTH fits.
  localparam logic [ADDR_W:0]    DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]    ONE_C   = (ADDR_W+1)'(1);
  localparam logic [STATE_W-1:0] DEPTH_B = STATE_W'(DEPTH);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    entry_q, entry_d;
  logic [1:0]         field_q, field_d;
  logic [ADDR_W:0]    n_q, n_d;
  logic [ADDR_W:0]    m_q, m_d;
  logic               err_q, err_d;
  logic [ADDR_W:0]    goto_count_q, goto_count_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [1:0]         wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [STATE_W-1:0] wr_data_q, wr_data_d;

  logic               accept;
  logic [STATE_W-1:0] in_byte;
  logic               count_ok;
  logic               chara_ok;

  assign in_byte  = bus.IN_DATA;
  assign accept   = in_ready_q & bus.IN_VALID;
  // A count byte is legal only in 1..DEPTH.
  assign count_ok = (in_byte != '0) && (in_byte <= DEPTH_B);
  // A chara byte must fit in CHARA_W bits.
  assign chara_ok = (in_byte[STATE_W-1:CHARA_W] == '0);

  // Next-state and next-output logic. Every write and status output is
  // computed here and registered below, so the write bus changes exactly one
  // cycle after the accepting edge or fill step that produced it.
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    field_d      = field_q;
    n_d          = n_q;
    m_d          = m_q;
    err_d        = err_q;
    goto_count_d = goto_count_q;
    wr_en_d      = 1'b0;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          err_d        = 1'b0;
          goto_count_d = '0;
          state_d      = GCNT;
        end
      end

      GCNT: begin
        if (accept) begin
          if (count_ok) begin
            n_d          = in_byte[ADDR_W:0];
            goto_count_d = in_byte[ADDR_W:0];
            entry_d      = '0;
            field_d      = 2'd0;
            state_d      = GOTO;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end

      GOTO: begin
        if (accept) begin
          if ((field_q == 2'd1) && !chara_ok) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            wr_en_d   = 1'b1;
            wr_sel_d  = field_q;
            wr_addr_d = entry_q[ADDR_W-1:0];
            wr_data_d = (field_q == 2'd1) ?
                        {{(STATE_W-CHARA_W){1'b0}}, in_byte[CHARA_W-1:0]} : in_byte;
            if (field_q == 2'd2) begin
              field_d = 2'd0;
              entry_d = entry_q + ONE_C;
              // entry_d already equals N, which is where the fill starts.
              if (entry_q == n_q - ONE_C) begin
                state_d = (n_q < DEPTH_C) ? GFILL : FCNT;
              end
            end else begin
              field_d = field_q + 2'd1;
            end
          end
        end
      end

      GFILL: begin
        wr_en_d   = 1'b1;
        wr_sel_d  = 2'd0;
        wr_addr_d = entry_q[ADDR_W-1:0];
        wr_data_d = INVALID_STATE;
        entry_d   = entry_q + ONE_C;
        if (entry_q == LAST_C) begin
          state_d = FCNT;
        end
      end

      FCNT: begin
        if (accept) begin
          if (count_ok) begin
            m_d     = in_byte[ADDR_W:0];
            entry_d = '0;
            state_d = FAIL;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end

      FAIL: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = 2'd3;
          wr_addr_d = entry_q[ADDR_W-1:0];
          wr_data_d = in_byte;
          entry_d   = entry_q + ONE_C;
          if (entry_q == m_q - ONE_C) begin
            state_d = (m_q < DEPTH_C) ? FFILL : FIN;
          end
        end
      end

      FFILL: begin
        wr_en_d   = 1'b1;
        wr_sel_d  = 2'd3;
        wr_addr_d = entry_q[ADDR_W-1:0];
        wr_data_d = '0;
        entry_d   = entry_q + ONE_C;
        if (entry_q == LAST_C) begin
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      ERROR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the upcoming state so they are clean
  // flop outputs. DONE follows the FIN cycle, i.e. it pulses in the cycle
  // right after the final table write becomes visible.
  always_comb begin
    in_ready_d = (state_d == GCNT) || (state_d == GOTO) ||
                 (state_d == FCNT) || (state_d == FAIL);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == FIN);
  end

  // State and output registers with synchronous active-low reset. Reset only
  // clears the writer; the table memories keep whatever was already written.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      entry_q      <= '0;
      field_q      <= 2'd0;
      n_q          <= '0;
      m_q          <= '0;
      err_q        <= 1'b0;
      goto_count_q <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= 2'd0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      field_q      <= field_d;
      n_q          <= n_d;
      m_q          <= m_d;
      err_q        <= err_d;
      goto_count_q <= goto_count_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.IN_READY   = in_ready_q;
  assign bus.WR_EN      = wr_en_q;
  assign bus.WR_SEL     = wr_sel_q;
  assign bus.WR_ADDR    = wr_addr_q;
  assign bus.WR_DATA    = wr_data_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.GOTO_COUNT = goto_count_q;

endmodule

// File: tb/tb_aho_table_writer.sv
// tb_aho_table_writer
// Self-checking bench for aho_table_writer. Streams are built per scenario,
// a reference model expands each stream into the expected list of table
// writes, and a monitor records every write the DUT actually issues.
module tb_aho_table_writer;

  localparam int DEPTH = 32;

  typedef logic [14:0] wr_t;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  aho_table_writer_if #(.ADDR_W(5), .STATE_W(8)) bus ();

  aho_table_writer #(
    .DEPTH(32), .ADDR_W(5), .STATE_W(8), .CHARA_W(4), .INVALID_STATE(8'hFF)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] stream[$];
  wr_t        exp_wr[$];
  wr_t        got[$];
  logic       exp_err;
  int         exp_done;
  int         exp_count;
  int         cur_n = 99;
  int         cur_m = 99;
  int         cyc = 0;
  int         done_count = 0;
  int         done_cyc = 0;
  int         last_wr_cyc = 0;
  int         fill_ready = 0;

  // Cycle counter used to relate DONE to the final write.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every visible write, DONE pulses, and any fill write
  // (other than the final address) seen while the stream input is ready.
  always @(negedge clk) begin
    if (bus.WR_EN === 1'b1) begin
      got.push_back({bus.WR_SEL, bus.WR_ADDR, bus.WR_DATA});
      last_wr_cyc = cyc;
      if (bus.IN_READY === 1'b1 && int'(bus.WR_ADDR) < DEPTH - 1 &&
          ((bus.WR_SEL == 2'd0 && int'(bus.WR_ADDR) >= cur_n) ||
           (bus.WR_SEL == 2'd3 && int'(bus.WR_ADDR) >= cur_m)))
        fill_ready++;
    end
    if (bus.DONE === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // Reference model: expands the stream into the table writes a loader must
  // perform, stopping at the first malformed byte.
  task automatic build_expected();
    int n;
    int m;
    int p;
    exp_wr.delete();
    exp_err   = 1'b0;
    exp_done  = 0;
    exp_count = 0;
    cur_n     = 99;
    cur_m     = 99;
    n = int'(stream[0]);
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    exp_count = n;
    cur_n     = n;
    for (int i = 0; i < n; i++) begin
      for (int f = 0; f < 3; f++) begin
        logic [7:0] b;
        b = stream[1 + 3*i + f];
        if (f == 1 && b[7:4] != 4'd0) begin
          exp_err = 1'b1;
          return;
        end
        exp_wr.push_back({2'(f), 5'(i), b});
      end
    end
    for (int i = n; i < DEPTH; i++) exp_wr.push_back({2'd0, 5'(i), 8'hFF});
    p = 1 + 3*n;
    m = int'(stream[p]);
    if (m == 0 || m > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    cur_m = m;
    for (int k = 0; k < m; k++) exp_wr.push_back({2'd3, 5'(k), stream[p + 1 + k]});
    for (int k = m; k < DEPTH; k++) exp_wr.push_back({2'd3, 5'(k), 8'h00});
    exp_done = 1;
  endtask

  // Index of the first difference between observed and expected writes, or -1.
  function automatic int first_diff();
    int lim;
    lim = (got.size() < exp_wr.size()) ? got.size() : exp_wr.size();
    for (int i = 0; i < lim; i++) if (got[i] !== exp_wr[i]) return i;
    if (got.size() != exp_wr.size()) return lim;
    return -1;
  endfunction

  function automatic wr_t got_at(input int i);
    return (i >= 0 && i < got.size()) ? got[i] : 15'h7fff;
  endfunction

  function automatic wr_t exp_at(input int i);
    return (i >= 0 && i < exp_wr.size()) ? exp_wr[i] : 15'h7fff;
  endfunction

  // Builds a well-formed stream with random goto triples and failure bytes.
  task automatic make_stream(input int n, input int m);
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      stream.push_back(8'($urandom));
      stream.push_back(8'($urandom_range(15, 0)));
      stream.push_back(8'($urandom));
    end
    stream.push_back(8'(m));
    for (int k = 0; k < m; k++) stream.push_back(8'($urandom));
  endtask

  // Presents one byte after 'gap' idle cycles and holds it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = b;
    while (bus.IN_READY !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout byte=%h ready=%b required 1", b, bus.IN_READY);
    end else begin
      @(posedge clk);
    end
    #1;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.BUSY === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout busy=%b required 0", bus.BUSY);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load(input int gap_max);
    got.delete();
    done_count = 0;
    fill_ready = 0;
    build_expected();
    pulse_start();
    foreach (stream[i]) send_byte(stream[i], int'($urandom_range(gap_max, 0)));
    wait_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.IN_READY, bus.WR_EN, bus.WR_SEL, bus.WR_ADDR, bus.WR_DATA,
         bus.BUSY, bus.DONE, bus.ERR, bus.GOTO_COUNT} !== 24'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs rdy=%b en=%b sel=%h addr=%h data=%h busy=%b done=%b err=%b cnt=%h required all 0",
               bus.IN_READY, bus.WR_EN, bus.WR_SEL, bus.WR_ADDR, bus.WR_DATA,
               bus.BUSY, bus.DONE, bus.ERR, bus.GOTO_COUNT);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_minimal_load();
    int d;
    stream = '{8'h01, 8'h00, 8'h0C, 8'h01, 8'h01, 8'h00};
    run_load(0);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL minimal_writes idx=%0d got=%h required=%h (got %0d writes, required %0d)",
               d, got_at(d), exp_at(d), got.size(), exp_wr.size());
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("[TB] FAIL minimal_done got %0d pulses required 1", done_count);
    end
    checks++;
    if (bus.GOTO_COUNT !== 6'd1 || bus.ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL minimal_status count=%0d err=%b required count=1 err=0", bus.GOTO_COUNT, bus.ERR);
    end
    checks++;
    if (fill_ready != 0) begin
      errors++;
      $display("[TB] FAIL minimal_fill_ready got %0d ready fill cycles required 0", fill_ready);
    end
  endtask

  task automatic test_full_tables();
    int  d;
    wr_t last;
    make_stream(32, 32);
    run_load(0);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL full_writes idx=%0d got=%h required=%h", d, got_at(d), exp_at(d));
    end
    checks++;
    if (got.size() != 128) begin
      errors++;
      $display("[TB] FAIL full_write_count got %0d required 128", got.size());
    end
    last = got_at(got.size() - 1);
    checks++;
    if (last[14:8] !== {2'd3, 5'd31}) begin
      errors++;
      $display("[TB] FAIL full_last_write got sel=%0d addr=%0d required sel=3 addr=31", last[14:13], last[12:8]);
    end
    checks++;
    if (done_count != 1 || done_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("[TB] FAIL full_done pulses=%0d cycle=%0d required 1 pulse at cycle %0d",
               done_count, done_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (bus.GOTO_COUNT !== 6'd32) begin
      errors++;
      $display("[TB] FAIL full_goto_count got %0d required 32", bus.GOTO_COUNT);
    end
  endtask

  task automatic test_bad_chara();
    int d;
    stream = '{8'h02, 8'h05, 8'h1C};
    got.delete();
    done_count = 0;
    build_expected();
    pulse_start();
    foreach (stream[i]) send_byte(stream[i], 0);
    checks++;
    if (bus.IN_READY !== 1'b0 || bus.BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bad_chara_ready ready=%b busy=%b required ready=0 busy=1", bus.IN_READY, bus.BUSY);
    end
    wait_idle();
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL bad_chara_writes idx=%0d got=%h required=%h (got %0d writes)", d, got_at(d), exp_at(d), got.size());
    end
    checks++;
    if (bus.ERR !== exp_err || done_count != 0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_chara_status err=%b done=%0d busy=%b required err=1 done=0 busy=0",
               bus.ERR, done_count, bus.BUSY);
    end
    pulse_start();
    checks++;
    if (bus.ERR !== 1'b0 || bus.GOTO_COUNT !== 6'd0 || bus.BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_clears_err err=%b cnt=%0d busy=%b required err=0 cnt=0 busy=1",
               bus.ERR, bus.GOTO_COUNT, bus.BUSY);
    end
    send_byte(8'h00, 0);
    wait_idle();
  endtask

  task automatic test_count_errors();
    int d;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) stream = '{8'h00};
      else if (r == 1) stream = '{8'h21};
      else make_stream(1, 0);
      run_load(0);
      d = first_diff();
      checks++;
      if (d != -1) begin
        errors++;
        $display("[TB] FAIL count_err_writes case=%0d idx=%0d got=%h required=%h (got %0d writes)",
                 r, d, got_at(d), exp_at(d), got.size());
      end
      checks++;
      if (bus.ERR !== 1'b1 || done_count != 0 || bus.GOTO_COUNT !== 6'(exp_count)) begin
        errors++;
        $display("[TB] FAIL count_err_status case=%0d err=%b done=%0d cnt=%0d required err=1 done=0 cnt=%0d",
                 r, bus.ERR, done_count, bus.GOTO_COUNT, exp_count);
      end
    end
  endtask

  task automatic test_gaps();
    wr_t base[$];
    int  d;
    make_stream(3, 4);
    run_load(0);
    base = got;
    run_load(5);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL gaps_writes idx=%0d got=%h required=%h", d, got_at(d), exp_at(d));
    end
    checks++;
    if (got != base) begin
      errors++;
      $display("[TB] FAIL gaps_vs_gapfree got %0d writes, gap-free run had %0d (sequences differ)", got.size(), base.size());
    end
    checks++;
    if (fill_ready != 0 || done_count != 1) begin
      errors++;
      $display("[TB] FAIL gaps_fill_ready ready_fill=%0d done=%0d required 0 and 1", fill_ready, done_count);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    for (int r = 0; r < 5; r++) begin
      make_stream(int'($urandom_range(32, 1)), int'($urandom_range(32, 1)));
      run_load((r % 2 == 1) ? 5 : 0);
      d = first_diff();
      checks++;
      if (d != -1) begin
        errors++;
        $display("[TB] FAIL random_writes run=%0d idx=%0d got=%h required=%h", r, d, got_at(d), exp_at(d));
      end
      checks++;
      if (done_count != 1 || done_cyc != last_wr_cyc + 1 || bus.ERR !== 1'b0 ||
          bus.GOTO_COUNT !== 6'(exp_count) || fill_ready != 0) begin
        errors++;
        $display("[TB] FAIL random_status run=%0d done=%0d dcyc=%0d lastwr=%0d err=%b cnt=%0d ready_fill=%0d required done=1 at lastwr+1 err=0 cnt=%0d ready_fill=0",
                 r, done_count, done_cyc, last_wr_cyc, bus.ERR, bus.GOTO_COUNT, fill_ready, exp_count);
      end
    end
  endtask

  task automatic test_ignored_start();
    int d;
    make_stream(5, 6);
    fork
      run_load(0);
      begin
        repeat (15) @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
      end
    join
    d = first_diff();
    checks++;
    if (d != -1 || done_count != 1) begin
      errors++;
      $display("[TB] FAIL ignored_start idx=%0d got=%h required=%h done=%0d required 1",
               d, got_at(d), exp_at(d), done_count);
    end
  endtask

  task automatic test_reset_mid_load();
    int n0;
    make_stream(2, 3);
    got.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(stream[i], 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.IN_READY, bus.WR_EN, bus.WR_SEL, bus.WR_ADDR, bus.WR_DATA,
         bus.BUSY, bus.DONE, bus.ERR, bus.GOTO_COUNT} !== 24'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs rdy=%b en=%b sel=%h addr=%h data=%h busy=%b done=%b err=%b cnt=%h required all 0",
               bus.IN_READY, bus.WR_EN, bus.WR_SEL, bus.WR_ADDR, bus.WR_DATA,
               bus.BUSY, bus.DONE, bus.ERR, bus.GOTO_COUNT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n0 = got.size();
    repeat (40) @(negedge clk);
    checks++;
    if (got.size() != n0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_writes got %0d writes after release busy=%b required 0 and 0",
               got.size() - n0, bus.BUSY);
    end
  endtask

  initial begin
    bus.START    = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'h00;
    rst_n        = 1'b0;
    $display("[TB] starting aho_table_writer bench");
    test_reset();
    test_minimal_load();
    test_full_tables();
    test_bad_chara();
    test_count_errors();
    test_gaps();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
